// File: rtl/op_pkg.sv
// rtl/op_pkg.sv - operation and accumulator state types shared by the op FIFO and its consumer
package op_pkg;

  typedef enum logic [1:0] {
    nop = 2'd0,
    add = 2'd1,
    sub = 2'd2,
    mul = 2'd3
  } operation_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } acc_state_t;

  // Width of a counter that must reach n-1 (never below 1 bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/op_accumulator_seq_multiplier.sv
// rtl/op_accumulator_seq_multiplier.sv - iterative shift-add multiplier, one multiplier bit per cycle
module seq_multiplier
  import op_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  valid,
  output logic [2*DATA_W-1:0]   prod
);

  localparam int BIT_W = cnt_width(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  logic [2*DATA_W-1:0] mcand_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [2*DATA_W-1:0] prod_next;
  logic [DATA_W-1:0]   mplier_q;
  logic [BIT_W-1:0]    bit_q;

  // The multiplicand shifts left and the multiplier right, so bit i lines up with mcand<<i.
  assign prod_next = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  assign valid     = busy & (bit_q == LAST_BIT);
  assign prod      = prod_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      bit_q    <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      mcand_q  <= {{DATA_W{1'b0}}, a};
      mplier_q <= b;
      prod_q   <= '0;
      bit_q    <= '0;
    end else if (busy) begin
      prod_q   <= prod_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      bit_q    <= bit_q + BIT_W'(1);
      if (valid) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/op_accumulator.sv
// rtl/op_accumulator.sv - pops operations from the op FIFO and applies them to a running accumulator
module op_accumulator
  import op_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic              empty,
  input  operation_t        rdata,
  input  logic [DATA_W-1:0] operand,
  output logic              fifo_pop,
  output logic [DATA_W-1:0] acc,
  output logic              ovf,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  op_count
);

  acc_state_t          state_q, state_d;
  logic [DATA_W-1:0]   acc_d;
  logic                ovf_d;
  logic                commit;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic                mul_start;
  logic                mul_busy;
  logic                mul_valid;
  logic [2*DATA_W-1:0] mul_prod;

  assign fifo_pop  = (state_q == IDLE) & enable & ~empty & ~clear & ~rst;
  assign mul_start = fifo_pop & (rdata == mul);
  assign busy      = (state_q == MUL);

  // The extra top bit is the carry for add and the borrow for sub.
  assign sum  = {1'b0, acc} + {1'b0, operand};
  assign diff = {1'b0, acc} - {1'b0, operand};

  seq_multiplier #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .abort (clear),
    .a     (acc),
    .b     (operand),
    .busy  (mul_busy),
    .valid (mul_valid),
    .prod  (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc;
    ovf_d   = ovf;
    commit  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            case (rdata)
              nop: commit = 1'b1;
              add: begin
                acc_d  = sum[DATA_W-1:0];
                ovf_d  = ovf | sum[DATA_W];
                commit = 1'b1;
              end
              sub: begin
                acc_d  = diff[DATA_W-1:0];
                ovf_d  = ovf | diff[DATA_W];
                commit = 1'b1;
              end
              mul: state_d = MUL;
              default: state_d = IDLE;
            endcase
          end
        end
        MUL: begin
          if (mul_valid) begin
            acc_d   = mul_prod[DATA_W-1:0];
            ovf_d   = ovf | (|mul_prod[2*DATA_W-1:DATA_W]);
            commit  = 1'b1;
            state_d = IDLE;
          end else if (!mul_busy) begin
            // Multiplier lost its operation without a result; never hang in MUL.
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc      <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      op_count <= '0;
    end else begin
      state_q  <= state_d;
      acc      <= acc_d;
      ovf      <= ovf_d;
      done     <= commit;
      op_count <= op_count + {{(CNT_W-1){1'b0}}, commit};
    end
  end

endmodule
